// File: rtl/conv_out_streamer_if.sv
// Row-major element stream leaving conv_out_streamer: valid/ready handshake
// with the element, its matrix indices and end-of-row / end-of-frame markers.
interface conv_out_streamer_if #(
  parameter int WIDTH_BIT = 16,
  parameter int IW        = 5
);
  logic                        out_valid;
  logic                        out_ready;
  logic signed [WIDTH_BIT-1:0] out_data;
  logic [IW-1:0]               out_row;
  logic [IW-1:0]               out_col;
  logic                        out_last_col;
  logic                        out_last;

  modport master (
    output out_valid, out_data, out_row, out_col, out_last_col, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_row, out_col, out_last_col, out_last,
    output out_ready
  );
endinterface

// File: rtl/conv_out_streamer.sv
// Snapshots the conv2 result matrix on a rising edge of done and streams it row-major, first
// element one cycle after the rise; a stall holds the element, and a rise while streaming is dropped.
module conv_out_streamer #(
  parameter  int SIZE      = 32,
  parameter  int SIZEKer   = 3,
  parameter  int WIDTH_BIT = 16,
  localparam int OUT       = SIZE - SIZEKer + 1,
  localparam int IW        = (OUT > 1) ? $clog2(OUT) : 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        done,
  input  logic signed [WIDTH_BIT-1:0] convIxKernelOut [OUT-1:0][OUT-1:0],
  output logic                        busy,
  output logic                        frame_done,
  output logic                        overrun,
  conv_out_streamer_if.master         st
);

  localparam logic [IW-1:0] LAST = IW'(OUT - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                      state, state_nx;
  logic                        done_q;
  logic                        rise, xfer, at_last, capture;
  logic [IW-1:0]               row, col, row_nx, col_nx;
  logic                        fd_nx, ovr_nx;
  logic signed [WIDTH_BIT-1:0] snap [OUT-1:0][OUT-1:0];

  assign rise    = done & ~done_q;
  assign at_last = (row == LAST) && (col == LAST);
  assign xfer    = (state == STREAM) && st.out_ready;

  always_comb begin
    state_nx = state;
    row_nx   = row;
    col_nx   = col;
    capture  = 1'b0;
    fd_nx    = 1'b0;
    ovr_nx   = overrun;
    case (state)
      IDLE: begin
        if (rise) begin
          capture  = 1'b1;
          state_nx = STREAM;
          row_nx   = '0;
          col_nx   = '0;
        end
      end
      STREAM: begin
        if (xfer && at_last) begin
          // A rise landing on the final transfer starts the next frame with no gap
          fd_nx  = 1'b1;
          row_nx = '0;
          col_nx = '0;
          if (rise) capture = 1'b1;
          else      state_nx = IDLE;
        end else begin
          if (xfer) begin
            if (col == LAST) begin
              col_nx = '0;
              row_nx = row + 1'b1;
            end else begin
              col_nx = col + 1'b1;
            end
          end
          if (rise) ovr_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      row        <= '0;
      col        <= '0;
      done_q     <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nx;
      row        <= row_nx;
      col        <= col_nx;
      done_q     <= done;
      frame_done <= fd_nx;
      overrun    <= ovr_nx;
    end
  end

  // Snapshot is only read while streaming, so it needs no reset
  always_ff @(posedge clock) begin
    if (capture) snap <= convIxKernelOut;
  end

  assign busy            = (state == STREAM);
  assign st.out_valid    = (state == STREAM);
  assign st.out_data     = snap[row][col];
  assign st.out_row      = row;
  assign st.out_col      = col;
  assign st.out_last_col = (col == LAST);
  assign st.out_last     = at_last;

endmodule
